// File: rtl/capture_pkg.sv
// Shared definitions for the capture sequencer: state encoding and trailer layout.
package capture_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_ARMED   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_FLUSH   = 3'd4,
        ST_DRAIN   = 3'd5
    } state_t;

    // Trailer word: sample_count in the low bits, overflow flag in the MSB.
    localparam int TRAILER_CNT_LSB = 0;

    function automatic int trailer_ovf_bit(input int data_w);
        return data_w - 1;
    endfunction

endpackage

// File: rtl/capture_sequencer_if.sv
// FIFO and host-readout signal bundle between the capture sequencer and its surroundings.
interface capture_sequencer_if #(
    parameter int DATA_W = 32
);
    // Strobes are single-cycle: wrreq writes o_fifo_data on that edge; rdreq pops and
    // i_fifo_q is valid the next cycle; i_read is honoured only while o_available=1,
    // and the word appears on o_data with o_valid=1 exactly one cycle later.
    logic              o_fifo_aclr;
    logic              o_fifo_wrreq;
    logic [DATA_W-1:0] o_fifo_data;
    logic              i_fifo_full;
    logic              i_fifo_empty;
    logic              o_fifo_rdreq;
    logic [DATA_W-1:0] i_fifo_q;
    logic              i_read;
    logic              o_available;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;

    modport master (
        output o_fifo_aclr, o_fifo_wrreq, o_fifo_data, o_fifo_rdreq,
        output o_available, o_data, o_valid,
        input  i_fifo_full, i_fifo_empty, i_fifo_q, i_read
    );

    modport slave (
        input  o_fifo_aclr, o_fifo_wrreq, o_fifo_data, o_fifo_rdreq,
        input  o_available, o_data, o_valid,
        output i_fifo_full, i_fifo_empty, i_fifo_q, i_read
    );
endinterface

// File: rtl/capture_readout.sv
// DRAIN-phase host readout: gates availability, issues FIFO reads, presents data a cycle later.
module capture_readout #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_drain,
    input  logic              abort,
    input  logic              read,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              available,
    output logic              rdreq,
    output logic              valid,
    output logic [DATA_W-1:0] data
);
    logic valid_q;

    always_comb begin
        available = in_drain & ~fifo_empty;
        rdreq     = available & read & ~abort;
        valid     = valid_q;
        data      = valid_q ? fifo_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= rdreq;
        end
    end
endmodule

// File: rtl/capture_sequencer.sv
// Run-level controller for one capture path: clear -> idle -> arm -> capture -> flush -> drain.
// Define CAPTURE_SEQUENCER_TRAILER_EN to append a {overflow, count} trailer word in FLUSH.
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int CLR_CYCLES  = 4,
    parameter int MAX_SAMPLES = 0
) (
    input  logic              i_clk,
    input  logic              mrst,
    input  logic              i_arm,
    input  logic              i_abort,
    input  logic              i_run,
    input  logic              i_save,
    input  logic [DATA_W-1:0] i_save_data,
    output logic              o_chan_rst_n,
    output logic              o_busy,
    output logic              o_overflow,
    output logic [CNT_W-1:0]  o_sample_count,
    output logic [2:0]        o_state,
    capture_sequencer_if.master bus
);
    localparam int               CLR_W    = $clog2(CLR_CYCLES + 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP      = CNT_W'(MAX_SAMPLES);

    state_t             state, state_nx;
    logic [CLR_W-1:0]   clr_cnt;
    logic [CNT_W-1:0]   sample_count, count_inc;
    logic               overflow;
    logic               wr_q;
    logic [DATA_W-1:0]  wr_data, trailer_word;
    logic               accept, drop, cap_hit, trailer_wr, trailer_drop;
    logic               in_drain;
`ifdef CAPTURE_SEQUENCER_TRAILER_EN
    logic               flush_second;
`endif

    always_comb begin
        state_nx     = state;
        accept       = 1'b0;
        drop         = 1'b0;
        cap_hit      = 1'b0;
        trailer_wr   = 1'b0;
        trailer_drop = 1'b0;
        count_inc    = (&sample_count) ? sample_count : sample_count + 1'b1;
        case (state)
            ST_CLEAR:   if (clr_cnt == CLR_LAST) state_nx = ST_IDLE;
            ST_IDLE:    if (i_arm) state_nx = ST_ARMED;
            ST_ARMED:   if (i_run) state_nx = ST_CAPTURE;
            ST_CAPTURE: begin
                accept  = i_save & ~bus.i_fifo_full;
                drop    = i_save & bus.i_fifo_full;
                cap_hit = (MAX_SAMPLES != 0) && accept && (count_inc >= CAP);
                if (!i_run || cap_hit) state_nx = ST_FLUSH;
            end
            ST_FLUSH: begin
`ifdef CAPTURE_SEQUENCER_TRAILER_EN
                if (flush_second) begin
                    trailer_wr   = ~bus.i_fifo_full;
                    trailer_drop = bus.i_fifo_full;
                    state_nx     = ST_DRAIN;
                end
`else
                state_nx = ST_DRAIN;
`endif
            end
            // Leave only once the FIFO is empty and the last read word has been presented.
            ST_DRAIN:   if (bus.i_fifo_empty && !bus.o_valid) state_nx = ST_IDLE;
            default:    state_nx = ST_CLEAR;
        endcase
        if (i_abort) begin
            state_nx     = ST_CLEAR;
            accept       = 1'b0;
            drop         = 1'b0;
            trailer_wr   = 1'b0;
            trailer_drop = 1'b0;
        end
    end

    always_comb begin
        trailer_word = '0;
        trailer_word[TRAILER_CNT_LSB +: CNT_W]  = sample_count;
        trailer_word[trailer_ovf_bit(DATA_W)]   = overflow;
    end

    always_ff @(posedge i_clk) begin
        if (mrst) begin
            state        <= ST_CLEAR;
            clr_cnt      <= '0;
            sample_count <= '0;
            overflow     <= 1'b0;
            wr_q         <= 1'b0;
            wr_data      <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= (state == ST_CLEAR && !i_abort) ? clr_cnt + 1'b1 : '0;
            if (state_nx == ST_CLEAR || (state == ST_IDLE && i_arm)) begin
                sample_count <= '0;
                overflow     <= 1'b0;
            end else begin
                if (accept) sample_count <= count_inc;
                if (drop || trailer_drop) overflow <= 1'b1;
            end
            wr_q <= accept;
            if (accept) wr_data <= i_save_data;
        end
    end

`ifdef CAPTURE_SEQUENCER_TRAILER_EN
    always_ff @(posedge i_clk) begin
        if (mrst) begin
            flush_second <= 1'b0;
        end else begin
            flush_second <= (state == ST_FLUSH) && !flush_second && !i_abort;
        end
    end
`endif

    assign in_drain         = (state == ST_DRAIN);
    assign bus.o_fifo_aclr  = (state == ST_CLEAR);
    assign bus.o_fifo_wrreq = (wr_q & ~i_abort) | trailer_wr;
    assign bus.o_fifo_data  = trailer_wr ? trailer_word : (wr_q ? wr_data : '0);
    assign o_chan_rst_n     = (state == ST_ARMED) || (state == ST_CAPTURE);
    assign o_busy           = (state != ST_IDLE);
    assign o_overflow       = overflow;
    assign o_sample_count   = sample_count;
    assign o_state          = state;

    capture_readout #(.DATA_W(DATA_W)) u_readout (
        .clk        (i_clk),
        .rst        (mrst),
        .in_drain   (in_drain),
        .abort      (i_abort),
        .read       (bus.i_read),
        .fifo_empty (bus.i_fifo_empty),
        .fifo_q     (bus.i_fifo_q),
        .available  (bus.o_available),
        .rdreq      (bus.o_fifo_rdreq),
        .valid      (bus.o_valid),
        .data       (bus.o_data)
    );
endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Run-level controller for one logic-analyzer capture path: sequences clear → arm → capture → drain → idle.
- Owns the channel_input reset line, the channel FIFO write/read strobes and the host readout handshake.
- Sits between a channel_input instance, the channel FIFO and the host read interface in main.
- Replaces the ad-hoc power-on counter and reset-ownership logic.

Parameters:
- DATA_W, 32, width of a sample/FIFO word.
- CNT_W, 16, width of the accepted-sample counter.
- CLR_CYCLES, 4, cycles the FIFO clear and channel reset are held in CLEAR (≥1).
- MAX_SAMPLES, 0, hard cap on accepted writes per capture; 0 = no cap.

Ports:
- i_clk in 1: sole clock; all logic is on the rising edge.
- mrst in 1: synchronous, active-high reset.
- i_arm in 1: start-capture pulse; only honoured in IDLE.
- i_abort in 1: forces CLEAR from any state.
- i_run in 1: channel_input run flag.
- i_save in 1: channel_input sample strobe.
- i_save_data in DATA_W: channel_input sample word.
- o_chan_rst_n out 1: active-low reset to channel_input; drives its _mrst.
- o_fifo_aclr out 1: FIFO clear.
- o_fifo_wrreq out 1: FIFO write strobe.
- o_fifo_data out DATA_W: FIFO write word.
- i_fifo_full in 1: FIFO full flag.
- i_fifo_empty in 1: FIFO empty flag.
- o_fifo_rdreq out 1: FIFO read strobe.
- i_fifo_q in DATA_W: FIFO read data (normal mode; valid the cycle after rdreq).
- i_read in 1: host read request.
- o_available out 1: a word can be read.
- o_data out DATA_W: host read data.
- o_valid out 1: o_data is valid this cycle.
- o_busy out 1: state is not IDLE.
- o_overflow out 1: sticky; a sample was dropped because the FIFO was full.
- o_sample_count out CNT_W: accepted writes in the current or last capture.
- o_state out 3: encoded state, for debug.

Behaviour:
- States: CLEAR=0, IDLE=1, ARMED=2, CAPTURE=3, FLUSH=4, DRAIN=5.
- Reset (mrst=1): state CLEAR, clear counter 0, o_fifo_aclr=1, o_chan_rst_n=0. All other outputs 0: wrreq, rdreq, valid, overflow, sample_count, data.
- CLEAR:
  - aclr=1 and chan_rst_n=0 for exactly CLR_CYCLES cycles, then IDLE.
  - On entry, clears overflow and sample_count.
- IDLE:
  - chan_rst_n=0.
  - i_arm=1 → ARMED next cycle; sample_count and overflow cleared on that edge.
- ARMED:
  - chan_rst_n=1.
  - First cycle with i_run=1 → CAPTURE.
- CAPTURE:
  - Each i_save=1 registers a write with 1-cycle latency: wrreq=1 and fifo_data=i_save_data on the next cycle.
  - If i_fifo_full=1 when i_save arrives: no write, overflow←1, count unchanged.
  - Each accepted write increments sample_count, saturating at all-ones.
  - End conditions: i_run falls (1→0), or the count reaches MAX_SAMPLES (when nonzero). Either → FLUSH.
  - A save in the same cycle as the end condition is still written.
  - Saves arriving after the end condition are ignored.
- FLUSH:
  - chan_rst_n=0.
  - Lasts one cycle so the last registered write completes, then DRAIN.
- DRAIN:
  - chan_rst_n=0; o_available = ~i_fifo_empty.
  - i_read & o_available → rdreq=1 for that cycle.
  - Next cycle: valid=1 and o_data=i_fifo_q.
  - i_read while not available is ignored.
  - At most one rdreq per cycle; back-to-back reads are allowed.
  - When i_fifo_empty=1 and no read is outstanding → IDLE.
- o_available=0 in every state other than DRAIN.
- i_abort=1 in any state → CLEAR next cycle; in-flight write and read strobes are dropped. i_abort wins over i_arm.
- mrst mid-capture behaves like abort, and also clears all registers.
- sample_count and overflow hold their values in IDLE until the next arm.

Optional Feature:
- CAPTURE_SEQUENCER_TRAILER_EN defined:
  - FLUSH lasts 2 cycles.
  - Second cycle writes a trailer word if the FIFO is not full: {overflow, zero pad, sample_count}, MSB = overflow.
  - The trailer is not counted in sample_count.
  - If the FIFO is full, the trailer is skipped and overflow←1.
- Undefined: no trailer; FLUSH is 1 cycle.

Decomposition:
- Shared package (capture_pkg): state encoding constants, trailer field positions.
- One natural sub-module: capture_readout, covering the DRAIN rdreq/valid handshake and o_available gating.
- State machine and counters stay in capture_sequencer.

Test Plan:
- Reset: hold mrst 2 cycles → aclr=1 for 4 cycles after release, then state=1. o_busy=0 and o_chan_rst_n=0 in IDLE.
- Basic capture (MAX_SAMPLES=0):
  - Stimulus: arm; run=1; saves of 0x11, 0x22, 0x33 on consecutive cycles; run=0.
  - Required: wrreq pulses 1 cycle after each save with matching data; sample_count=3; state reaches DRAIN.
- Cap: MAX_SAMPLES=7, 10 saves → exactly 7 writes; FLUSH entered on the 7th.
- Overflow: hold i_fifo_full=1 on the 2nd of 3 saves → 2 writes; overflow=1; count=2.
- Drain:
  - Stimulus: 3 words in FIFO; i_read held high.
  - Required: rdreq on 3 consecutive cycles; valid on the following 3 with 0x11, 0x22, 0x33; then IDLE.
- Abort mid-CAPTURE → CLEAR next cycle; no further wrreq; chan_rst_n=0. With trailer enabled, the basic capture ends with trailer 0x00000003.
